sysx_device_endpoint: RTL and testbench
=======================================

Name: sysx_device_endpoint

Overview:
- Peripheral-side endpoint of the sysX v1 bus: the responder to the sysX master controller.
- Oversamples the bus clock, select and MOSI lines in the local clock domain.
- Assembles each 5-phase bus word (Load, byte0..byte3, LSB first) into a 32-bit RX word and returns a 32-bit TX word on MISO.
- Raises the bus interrupt while a TX word is pending; sits between the sysX cable pins and a local device core.

Parameters:
- DEVICE_SELECT, 2'd1: bus select code this endpoint answers to (1..3; 0 = bus idle).
- IDLE_PATTERN, 32'hFFFFFFFF: MISO word returned when no TX word is pending.
- SYNC_STAGES, 2: flip-flop depth of the input synchronizers (minimum 2).

Ports:
- iClock  in  1  local clock; must be at least 8x the bus clock frequency.
- iReset  in  1  synchronous, active-low reset.
- iBusClock  in  1  sysX bus clock; idles high.
- iBusSelect  in  2  sysX chip select.
- iBusMOSI  in  8  master-to-device byte.
- oBusMISO  out  8  device-to-master byte.
- oBusMISOEnable  out  1  high while this endpoint drives MISO.
- oBusInterrupt  out  1  TX word pending.
- oRxData  out  32  received word.
- oRxValid  out  1  oRxData holds an unread word.
- iRxReady  in  1  local side consumes oRxData.
- oRxOverrun  out  1  sticky: a word was dropped.
- iRxOverrunClear  in  1  clears oRxOverrun.
- iTxData  in  32  word to return on the next bus transfer.
- iTxValid  in  1  offer iTxData.
- oTxReady  out  1  TX holding register empty.
- oBusy  out  1  selected and mid-word.

Behaviour:
- Reset (iReset=0 at a posedge of iClock): state DESEL; all outputs 0 except oTxReady=1; holding registers invalid; synchronizers loaded with the idle level (clock=1, select=0, MOSI=0).
- Inputs pass through SYNC_STAGES flip-flops. A falling edge is detected as previous synced clock=1 and current=0. Edge detection has SYNC_STAGES+1 iClock of latency from the pin.
- sel = (synced iBusSelect == DEVICE_SELECT). If sel is low in any state, go to DESEL: byte counter cleared, partial RX word discarded, MISO enable low. The TX holding register is not touched.
- State machine, advancing only on a detected falling edge while sel is high:
  - DESEL -> WAIT_LOAD when sel rises. No edge is needed.
  - WAIT_LOAD (falling edge = master Load phase) -> BYTE0. Shift register loads the TX holding word if valid, otherwise IDLE_PATTERN. oBusMISO=bits[7:0]; oBusMISOEnable=1.
  - BYTEk for k=0..2 (edge): capture synced MOSI into RX bits[8k+7:8k]; drive MISO bits[8k+15:8k+8]; go to BYTEk+1.
  - BYTE3 (edge): capture bits[31:24]; word complete; go to WAIT_LOAD. The master's Store phase holds the clock high, so no edge occurs there.
- MISO timing: MISO updates 1 iClock after edge detection, so it is stable well before the master samples on the next falling edge.
- oBusy = state in BYTE0..BYTE3.
- Word complete:
  - If the RX holding register is empty, or iRxReady=1 in the same cycle: oRxData <= word, oRxValid=1 on the next cycle.
  - Otherwise the word is dropped and oRxOverrun is set. On a simultaneous iRxOverrunClear, set wins.
  - If the TX word was taken at Load, the TX holding register clears (oTxReady=1 next cycle).
- TX side:
  - oTxReady = !txValid. An iTxValid&&oTxReady cycle loads the holding register.
  - iTxValid is ignored while the register is full.
  - A deselect mid-word leaves the TX word pending; it is resent in full on the next transfer.
- oBusInterrupt = txValid, registered.
- RX handshake: iRxValid&&iRxReady pops, so oRxValid falls on the next cycle unless a new word completes in that same cycle.
- Reset mid-word: immediate return to reset state; the bus master sees MISO released.

Optional Feature:
- SYSX_DEVICE_RXFIFO_EN defined: the RX holding register becomes a 4-entry FIFO.
  - oRxValid = not empty; oRxData = head.
  - Overrun only when 4 entries are full at word complete.
  - A simultaneous push and pop on a full FIFO is legal.
- Undefined: single-entry holding register as above.

Decomposition:
- Package sysx_pkg: state encoding (DESEL, WAIT_LOAD, BYTE0..BYTE3), SYSX_SEL_IDLE=2'd0, byte-phase count 4, default IDLE_PATTERN.
- Sub-module sysx_device_rxfifo: 4x32 synchronous FIFO, instantiated only under SYSX_DEVICE_RXFIFO_EN.

Test Plan:
- Select=1, MOSI bytes 0x78,0x56,0x34,0x12, no TX pending -> oRxData=32'h12345678 with oRxValid=1; MISO bytes FF,FF,FF,FF.
- iTxData=32'hCAFEF00D loaded, oBusInterrupt=1; one transfer -> MISO bytes 0D,F0,FE,CA; oTxReady=1 and oBusInterrupt=0 after completion.
- Two back-to-back words, iRxReady held 0 -> first word retained, oRxOverrun=1; iRxOverrunClear -> 0. With FIFO enabled, 5 words are needed to overrun.
- Select=2 with DEVICE_SELECT=1 -> no RX word, oBusMISOEnable stays 0.
- Deselect after byte1 with TX 32'hA5A5_0001 pending -> no RX word, TX still pending; the next full transfer returns 01,00,A5,A5.
- iReset low during BYTE2 -> all outputs at reset values next cycle; the following full transfer is received correctly.

Source files
------------

// File: rtl/sysx_pkg.sv
// rtl/sysx_pkg.sv - shared state encoding and constants for the sysX device endpoint
package sysx_pkg;

    typedef enum logic [2:0] {
        SYSX_DESEL,
        SYSX_WAIT_LOAD,
        SYSX_BYTE0,
        SYSX_BYTE1,
        SYSX_BYTE2,
        SYSX_BYTE3
    } sysx_state_e;

    localparam logic [1:0]  SYSX_SEL_IDLE             = 2'd0;
    localparam int          SYSX_BYTE_PHASES          = 4;
    localparam int          SYSX_WORD_BITS            = SYSX_BYTE_PHASES * 8;
    localparam logic [31:0] SYSX_IDLE_PATTERN_DEFAULT = 32'hFFFF_FFFF;

endpackage

// File: rtl/sysx_device_endpoint_if.sv
// rtl/sysx_device_endpoint_if.sv - sysX cable-side pins between bus master and device endpoint
interface sysx_device_endpoint_if;
    logic       iBusClock;
    logic [1:0] iBusSelect;
    logic [7:0] iBusMOSI;
    logic [7:0] oBusMISO;
    logic       oBusMISOEnable;
    logic       oBusInterrupt;

    modport master (
        output iBusClock, iBusSelect, iBusMOSI,
        input  oBusMISO, oBusMISOEnable, oBusInterrupt
    );

    modport slave (
        input  iBusClock, iBusSelect, iBusMOSI,
        output oBusMISO, oBusMISOEnable, oBusInterrupt
    );
endinterface

// File: rtl/sysx_device_rxfifo.sv
// rtl/sysx_device_rxfifo.sv - 4x32 RX word FIFO, used when SYSX_DEVICE_RXFIFO_EN is defined
module sysx_device_rxfifo
    import sysx_pkg::*;
(
    input  logic                      clk_i,
    input  logic                      resetn_i,
    input  logic                      push_i,
    input  logic [SYSX_WORD_BITS-1:0] data_i,
    input  logic                      pop_i,
    output logic [SYSX_WORD_BITS-1:0] data_o,
    output logic                      empty_o,
    output logic                      full_o
);
    logic [SYSX_WORD_BITS-1:0] mem_q [4];
    logic [1:0]                wr_q;
    logic [1:0]                rd_q;
    logic [2:0]                count_q;

    // Push on a full FIFO is only issued together with a pop, so wr_q == rd_q is safe to overwrite.
    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            for (int i = 0; i < 4; i++) mem_q[i] <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= wr_q + 2'd1;
            end
            if (pop_i) rd_q <= rd_q + 2'd1;
            count_q <= count_q + 3'(push_i) - 3'(pop_i);
        end
    end

    assign data_o  = mem_q[rd_q];
    assign empty_o = (count_q == 3'd0);
    assign full_o  = (count_q == 3'd4);
endmodule

// File: rtl/sysx_device_endpoint.sv
// rtl/sysx_device_endpoint.sv - sysX v1 device endpoint; SYSX_DEVICE_RXFIFO_EN selects a 4-deep RX FIFO
module sysx_device_endpoint
    import sysx_pkg::*;
#(
    parameter logic [1:0]  DEVICE_SELECT = 2'd1,
    parameter logic [31:0] IDLE_PATTERN  = SYSX_IDLE_PATTERN_DEFAULT,
    parameter int          SYNC_STAGES   = 2
) (
    input  logic                  iClock,
    input  logic                  iReset,
    sysx_device_endpoint_if.slave bus,
    output logic [31:0]           oRxData,
    output logic                  oRxValid,
    input  logic                  iRxReady,
    output logic                  oRxOverrun,
    input  logic                  iRxOverrunClear,
    input  logic [31:0]           iTxData,
    input  logic                  iTxValid,
    output logic                  oTxReady,
    output logic                  oBusy
);
    localparam logic [10:0] SyncIdle = {1'b1, SYSX_SEL_IDLE, 8'h00};

    logic [10:0] sync_q [SYNC_STAGES];
    logic        clk_s;
    logic [1:0]  sel_s;
    logic [7:0]  mosi_s;
    logic        clk_prev_q;
    logic        fall;
    logic        sel;

    always_ff @(posedge iClock) begin
        if (!iReset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SyncIdle;
            clk_prev_q <= 1'b1;
        end else begin
            sync_q[0] <= {bus.iBusClock, bus.iBusSelect, bus.iBusMOSI};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            clk_prev_q <= clk_s;
        end
    end

    assign {clk_s, sel_s, mosi_s} = sync_q[SYNC_STAGES-1];
    assign fall = clk_prev_q & ~clk_s;
    assign sel  = (sel_s == DEVICE_SELECT);

    sysx_state_e state_q, state_d;
    logic [23:0] tx_shift_q, tx_shift_d;
    logic [23:0] rx_shift_q, rx_shift_d;
    logic [7:0]  miso_q, miso_d;
    logic        miso_en_q, miso_en_d;
    logic        tx_taken_q, tx_taken_d;
    logic        tx_valid_q, tx_valid_d;
    logic [31:0] tx_data_q, tx_data_d;
    logic        overrun_q, overrun_d;
    logic        word_done;
    logic [31:0] load_word;
    logic [31:0] rx_word;
    logic        rx_push;
    logic        rx_drop;

    assign load_word = tx_valid_q ? tx_data_q : IDLE_PATTERN;
    assign rx_word   = {mosi_s, rx_shift_q};

    always_comb begin
        state_d    = state_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        miso_d     = miso_q;
        miso_en_d  = miso_en_q;
        tx_taken_d = tx_taken_q;
        word_done  = 1'b0;
        if (!sel) begin
            state_d    = SYSX_DESEL;
            miso_en_d  = 1'b0;
            rx_shift_d = '0;
            tx_taken_d = 1'b0;
        end else begin
            unique case (state_q)
                SYSX_DESEL: state_d = SYSX_WAIT_LOAD;
                SYSX_WAIT_LOAD: if (fall) begin
                    state_d    = SYSX_BYTE0;
                    tx_taken_d = tx_valid_q;
                    tx_shift_d = load_word[31:8];
                    miso_d     = load_word[7:0];
                    miso_en_d  = 1'b1;
                end
                SYSX_BYTE0, SYSX_BYTE1, SYSX_BYTE2: if (fall) begin
                    rx_shift_d = {mosi_s, rx_shift_q[23:8]};
                    miso_d     = tx_shift_q[7:0];
                    tx_shift_d = {8'h00, tx_shift_q[23:8]};
                    state_d    = (state_q == SYSX_BYTE0) ? SYSX_BYTE1 :
                                 (state_q == SYSX_BYTE1) ? SYSX_BYTE2 : SYSX_BYTE3;
                end
                // The Store phase keeps the bus clock high, so the next edge is the next Load.
                SYSX_BYTE3: if (fall) begin
                    word_done = 1'b1;
                    state_d   = SYSX_WAIT_LOAD;
                end
                default: state_d = SYSX_DESEL;
            endcase
        end

        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        if (word_done && tx_taken_q) begin
            tx_valid_d = 1'b0;
        end else if (iTxValid && !tx_valid_q) begin
            tx_valid_d = 1'b1;
            tx_data_d  = iTxData;
        end

        overrun_d = overrun_q;
        if (rx_drop)              overrun_d = 1'b1;
        else if (iRxOverrunClear) overrun_d = 1'b0;
    end

    always_ff @(posedge iClock) begin
        if (!iReset) begin
            state_q    <= SYSX_DESEL;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            miso_q     <= '0;
            miso_en_q  <= 1'b0;
            tx_taken_q <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            miso_q     <= miso_d;
            miso_en_q  <= miso_en_d;
            tx_taken_q <= tx_taken_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            overrun_q  <= overrun_d;
        end
    end

`ifdef SYSX_DEVICE_RXFIFO_EN
    logic fifo_empty;
    logic fifo_full;
    logic rx_pop;

    assign rx_pop  = iRxReady & ~fifo_empty;
    assign rx_push = word_done & (~fifo_full | rx_pop);

    sysx_device_rxfifo u_rxfifo (
        .clk_i    (iClock),
        .resetn_i (iReset),
        .push_i   (rx_push),
        .data_i   (rx_word),
        .pop_i    (rx_pop),
        .data_o   (oRxData),
        .empty_o  (fifo_empty),
        .full_o   (fifo_full)
    );

    assign oRxValid = ~fifo_empty;
`else
    logic        rx_valid_q, rx_valid_d;
    logic [31:0] rx_data_q, rx_data_d;

    assign rx_push = word_done & (~rx_valid_q | iRxReady);

    always_comb begin
        rx_valid_d = rx_valid_q;
        rx_data_d  = rx_data_q;
        if (rx_push) begin
            rx_valid_d = 1'b1;
            rx_data_d  = rx_word;
        end else if (iRxReady) begin
            rx_valid_d = 1'b0;
        end
    end

    always_ff @(posedge iClock) begin
        if (!iReset) begin
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
        end else begin
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
        end
    end

    assign oRxValid = rx_valid_q;
    assign oRxData  = rx_data_q;
`endif

    assign rx_drop = word_done & ~rx_push;

    assign bus.oBusMISO       = miso_q;
    assign bus.oBusMISOEnable = miso_en_q;
    assign bus.oBusInterrupt  = tx_valid_q;
    assign oTxReady           = ~tx_valid_q;
    assign oRxOverrun         = overrun_q;
    assign oBusy              = (state_q == SYSX_BYTE0) || (state_q == SYSX_BYTE1) ||
                                (state_q == SYSX_BYTE2) || (state_q == SYSX_BYTE3);
endmodule

// File: tb/tb_sysx_device_endpoint.sv
// tb/tb_sysx_device_endpoint.sv - self-checking bench for sysx_device_endpoint
module tb_sysx_device_endpoint;
    localparam int H = 8;
`ifdef SYSX_DEVICE_RXFIFO_EN
    localparam int RXD = 4;
`else
    localparam int RXD = 1;
`endif

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic        rx_ready = 1'b0;
    logic        rx_overrun;
    logic        ovr_clear = 1'b0;
    logic [31:0] tx_data = '0;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic        busy;

    int checks = 0;
    int failures = 0;

    sysx_device_endpoint_if bus_if ();

    sysx_device_endpoint #(
        .DEVICE_SELECT (2'd1),
        .IDLE_PATTERN  (32'hFFFF_FFFF),
        .SYNC_STAGES   (2)
    ) dut (
        .iClock          (clk),
        .iReset          (rstn),
        .bus             (bus_if),
        .oRxData         (rx_data),
        .oRxValid        (rx_valid),
        .iRxReady        (rx_ready),
        .oRxOverrun      (rx_overrun),
        .iRxOverrunClear (ovr_clear),
        .iTxData         (tx_data),
        .iTxValid        (tx_valid),
        .oTxReady        (tx_ready),
        .oBusy           (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_tx(input logic [31:0] w);
        tx_data  = w;
        tx_valid = 1'b1;
        wait_cyc(1);
        tx_valid = 1'b0;
        wait_cyc(1);
    endtask

    task automatic pop_rx();
        rx_ready = 1'b1;
        wait_cyc(1);
        rx_ready = 1'b0;
    endtask

    task automatic pulse_clear();
        ovr_clear = 1'b1;
        wait_cyc(1);
        ovr_clear = 1'b0;
    endtask

    // Master side of one transfer: Load phase, then nbytes byte phases, MISO sampled before each fall.
    task automatic xfer(input logic [1:0] sel, input logic [31:0] mosi, input int nbytes,
                        input bit release_sel, output logic [31:0] miso, output logic en_seen);
        miso    = '0;
        en_seen = 1'b0;
        bus_if.iBusSelect = sel;
        wait_cyc(6);
        bus_if.iBusClock = 1'b0; wait_cyc(H);
        bus_if.iBusClock = 1'b1; wait_cyc(H);
        for (int k = 0; k < nbytes; k++) begin
            bus_if.iBusMOSI = mosi[8*k +: 8];
            wait_cyc(2);
            miso[8*k +: 8] = bus_if.oBusMISO;
            en_seen = en_seen | bus_if.oBusMISOEnable;
            bus_if.iBusClock = 1'b0; wait_cyc(H);
            bus_if.iBusClock = 1'b1; wait_cyc(H);
        end
        if (release_sel) begin
            bus_if.iBusSelect = 2'd0;
            wait_cyc(6);
        end
    endtask

    typedef struct {
        logic [1:0]  sel;
        bit          load;
        logic [31:0] tx;
        logic [31:0] mosi;
        logic [31:0] exp_miso;
        bit          exp_en;
        bit          exp_rxv;
        bit          exp_txready;
        bit          exp_irq_pre;
    } vec_t;

    vec_t        vecs [5];
    logic [31:0] miso;
    logic        en;
    logic [31:0] rxq [$];
    bit          m_ovr;
    bit          m_txp;
    logic [31:0] m_txw;

    initial begin
        vecs[0] = '{2'd1, 1'b0, 32'h0,         32'h1234_5678, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{2'd1, 1'b1, 32'hCAFE_F00D, 32'h0BAD_BEEF, 32'hCAFE_F00D, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[2] = '{2'd2, 1'b0, 32'h0,         32'hDEAD_BEEF, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{2'd3, 1'b1, 32'h1122_3344, 32'h0102_0304, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{2'd1, 1'b0, 32'h0,         32'h55AA_55AA, 32'h1122_3344, 1'b1, 1'b1, 1'b1, 1'b1};

        bus_if.iBusClock  = 1'b1;
        bus_if.iBusSelect = 2'd0;
        bus_if.iBusMOSI   = 8'h00;
        wait_cyc(3);
        check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("reset_rx_data", rx_data, 32'd0);
        check("reset_overrun", {31'd0, rx_overrun}, 32'd0);
        check("reset_tx_ready", {31'd0, tx_ready}, 32'd1);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_miso_en", {31'd0, bus_if.oBusMISOEnable}, 32'd0);
        check("reset_irq", {31'd0, bus_if.oBusInterrupt}, 32'd0);
        check("reset_miso", {24'd0, bus_if.oBusMISO}, 32'd0);
        rstn = 1'b1;
        wait_cyc(4);

        for (int i = 0; i < 5; i++) begin
            if (vecs[i].load) load_tx(vecs[i].tx);
            check("vec_irq_pre", {31'd0, bus_if.oBusInterrupt}, {31'd0, vecs[i].exp_irq_pre});
            xfer(vecs[i].sel, vecs[i].mosi, 4, 1'b1, miso, en);
            if (vecs[i].exp_en) check("vec_miso", miso, vecs[i].exp_miso);
            check("vec_miso_en", {31'd0, en}, {31'd0, vecs[i].exp_en});
            check("vec_rx_valid", {31'd0, rx_valid}, {31'd0, vecs[i].exp_rxv});
            if (vecs[i].exp_rxv) check("vec_rx_data", rx_data, vecs[i].mosi);
            check("vec_tx_ready", {31'd0, tx_ready}, {31'd0, vecs[i].exp_txready});
            check("vec_irq_post", {31'd0, bus_if.oBusInterrupt}, {31'd0, !vecs[i].exp_txready});
            if (vecs[i].exp_rxv) begin
                pop_rx();
                check("vec_rx_popped", {31'd0, rx_valid}, 32'd0);
            end
        end

        // Overrun: one more word than the RX storage holds, nothing consumed.
        for (int i = 0; i <= RXD; i++) xfer(2'd1, 32'h1000_0000 + i, 4, 1'b0, miso, en);
        bus_if.iBusSelect = 2'd0;
        wait_cyc(6);
        check("ovr_set", {31'd0, rx_overrun}, 32'd1);
        for (int i = 0; i < RXD; i++) begin
            check("ovr_rx_valid", {31'd0, rx_valid}, 32'd1);
            check("ovr_rx_data", rx_data, 32'h1000_0000 + i);
            pop_rx();
        end
        check("ovr_drained", {31'd0, rx_valid}, 32'd0);
        check("ovr_sticky", {31'd0, rx_overrun}, 32'd1);
        pulse_clear();
        check("ovr_cleared", {31'd0, rx_overrun}, 32'd0);

        // Deselect after byte1 leaves the TX word pending for a full resend.
        load_tx(32'hA5A5_0001);
        xfer(2'd1, 32'h0000_2222, 2, 1'b1, miso, en);
        check("desel_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("desel_tx_ready", {31'd0, tx_ready}, 32'd0);
        check("desel_irq", {31'd0, bus_if.oBusInterrupt}, 32'd1);
        xfer(2'd1, 32'h3333_4444, 4, 1'b1, miso, en);
        check("resend_miso", miso, 32'hA5A5_0001);
        check("resend_rx_data", rx_data, 32'h3333_4444);
        check("resend_tx_ready", {31'd0, tx_ready}, 32'd1);
        pop_rx();

        // Reset while in BYTE2.
        load_tx(32'h0BAD_F00D);
        xfer(2'd1, 32'h9999_8888, 2, 1'b0, miso, en);
        check("midword_busy", {31'd0, busy}, 32'd1);
        rstn = 1'b0;
        wait_cyc(1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_miso_en", {31'd0, bus_if.oBusMISOEnable}, 32'd0);
        check("rst_irq", {31'd0, bus_if.oBusInterrupt}, 32'd0);
        check("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
        check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        rstn = 1'b1;
        bus_if.iBusSelect = 2'd0;
        wait_cyc(4);
        xfer(2'd1, 32'h1357_9BDF, 4, 1'b1, miso, en);
        check("post_rst_miso", miso, 32'hFFFF_FFFF);
        check("post_rst_rx_data", rx_data, 32'h1357_9BDF);
        check("post_rst_rx_valid", {31'd0, rx_valid}, 32'd1);
        pop_rx();

        // Randomized traffic against a queue-based model of the endpoint.
        m_ovr = 1'b0;
        m_txp = 1'b0;
        m_txw = '0;
        for (int it = 0; it < 25; it++) begin
            logic [31:0] w;
            logic [1:0]  s;
            w = $urandom;
            if ($urandom_range(0, 9) < 5) begin
                load_tx(w);
                if (!m_txp) begin
                    m_txp = 1'b1;
                    m_txw = w;
                end
            end
            s = ($urandom_range(0, 9) < 8) ? 2'd1 : 2'($urandom_range(2, 3));
            w = $urandom;
            xfer(s, w, 4, 1'b1, miso, en);
            if (s == 2'd1) begin
                check("rnd_miso", miso, m_txp ? m_txw : 32'hFFFF_FFFF);
                m_txp = 1'b0;
                if (rxq.size() < RXD) rxq.push_back(w);
                else m_ovr = 1'b1;
            end
            check("rnd_miso_en", {31'd0, en}, {31'd0, s == 2'd1});
            check("rnd_tx_ready", {31'd0, tx_ready}, {31'd0, !m_txp});
            check("rnd_irq", {31'd0, bus_if.oBusInterrupt}, {31'd0, m_txp});
            check("rnd_rx_valid", {31'd0, rx_valid}, {31'd0, rxq.size() > 0});
            if (rxq.size() > 0) check("rnd_rx_data", rx_data, rxq[0]);
            check("rnd_overrun", {31'd0, rx_overrun}, {31'd0, m_ovr});
            if ($urandom_range(0, 1) == 1) begin
                pop_rx();
                if (rxq.size() > 0) void'(rxq.pop_front());
                check("rnd_pop_valid", {31'd0, rx_valid}, {31'd0, rxq.size() > 0});
            end
            if ($urandom_range(0, 4) == 0) begin
                pulse_clear();
                m_ovr = 1'b0;
                check("rnd_ovr_clear", {31'd0, rx_overrun}, 32'd0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
